// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core: operand forwarding from EX/MEM/WB,
// load-use stall with bubble insertion, branch flush, and stall/flush event counters.
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_id,
  input  logic [31:0]       pc_id,
  input  logic [4:0]        rR1,
  input  logic [4:0]        rR2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [31:0]       rD1,
  input  logic [31:0]       rD2,
  input  logic [31:0]       sext,
  input  logic [4:0]        wR_id,
  input  logic              rf_we_id,
  input  logic [1:0]        wd_sel_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic [31:0]       alu_c_ex,
  input  logic [31:0]       wD_mem,
  input  logic [4:0]        wR_mem,
  input  logic              rf_we_mem,
  input  logic [31:0]       wD,
  input  logic [4:0]        wR_wb,
  input  logic              rf_we_wb,
  input  logic              flush,
  output logic              stall_o,
  output logic              valid_ex,
  output logic [31:0]       pc_ex,
  output logic [31:0]       rD1_ex,
  output logic [31:0]       rD2_ex,
  output logic [31:0]       sext_ex,
  output logic [4:0]        wR_ex,
  output logic              rf_we_ex,
  output logic [1:0]        wd_sel_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_DRAM = 2'b01;
  localparam logic [1:0] WD_PC4  = 2'b10;
  localparam logic [1:0] WD_SEXT = 2'b11;

  logic              valid_q,  valid_d;
  logic [31:0]       pc_q,     pc_d;
  logic [31:0]       rd1_q,    rd1_d;
  logic [31:0]       rd2_q,    rd2_d;
  logic [31:0]       sext_q,   sext_d;
  logic [4:0]        wr_q,     wr_d;
  logic              we_q,     we_d;
  logic [1:0]        wd_sel_q, wd_sel_d;
  logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic        ex_fwd_ok;
  logic [31:0] ex_val;
  logic [31:0] fwd1, fwd2;
  logic        load_use;

  // A load in EX has no value yet; its consumers are caught by load_use instead.
  assign ex_fwd_ok = valid_q & we_q & (wd_sel_q != WD_DRAM);

  always_comb begin
    ex_val = alu_c_ex;
    case (wd_sel_q)
      WD_PC4:  ex_val = pc_q + 32'd4;
      WD_SEXT: ex_val = sext_q;
      default: ex_val = alu_c_ex;
    endcase
  end

  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  src,
    input logic [31:0] rf_val,
    input logic        ex_ok,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_v,
    input logic        mem_we,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_v,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_v
  );
    logic [31:0] r;
    r = rf_val;
    if (src != 5'd0) begin
      if (ex_ok && ex_rd == src)         r = ex_v;
      else if (mem_we && mem_rd == src)  r = mem_v;
      else if (wb_we && wb_rd == src)    r = wb_v;
    end
    return r;
  endfunction

  assign fwd1 = fwd_sel(rR1, rD1, ex_fwd_ok, wr_q, ex_val,
                        rf_we_mem, wR_mem, wD_mem, rf_we_wb, wR_wb, wD);
  assign fwd2 = fwd_sel(rR2, rD2, ex_fwd_ok, wr_q, ex_val,
                        rf_we_mem, wR_mem, wD_mem, rf_we_wb, wR_wb, wD);

  assign load_use = valid_id & valid_q & we_q & (wd_sel_q == WD_DRAM) & (wr_q != 5'd0) &
                    ((rs1_used & (rR1 == wr_q)) | (rs2_used & (rR2 == wr_q)));

  assign stall_o = load_use & ~flush;

  always_comb begin
    valid_d  = 1'b0;
    pc_d     = '0;
    rd1_d    = '0;
    rd2_d    = '0;
    sext_d   = '0;
    wr_d     = '0;
    we_d     = 1'b0;
    wd_sel_d = WD_ALU;
    ctrl_d   = '0;
    if (!flush && !load_use && valid_id) begin
      valid_d  = 1'b1;
      pc_d     = pc_id;
      rd1_d    = fwd1;
      rd2_d    = fwd2;
      sext_d   = sext;
      wr_d     = wR_id;
      we_d     = rf_we_id;
      wd_sel_d = wd_sel_id;
      ctrl_d   = ctrl_id;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && flush_cnt_q != {CNT_W{1'b1}})   flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      sext_q      <= '0;
      wr_q        <= '0;
      we_q        <= 1'b0;
      wd_sel_q    <= WD_ALU;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      sext_q      <= sext_d;
      wr_q        <= wr_d;
      we_q        <= we_d;
      wd_sel_q    <= wd_sel_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign valid_ex  = valid_q;
  assign pc_ex     = pc_q;
  assign rD1_ex    = rd1_q;
  assign rD2_ex    = rd2_q;
  assign sext_ex   = sext_q;
  assign wR_ex     = wr_q;
  assign rf_we_ex  = we_q;
  assign wd_sel_ex = wd_sel_q;
  assign ctrl_ex   = ctrl_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural pipeline model predicts each
// captured EX slot; a monitor pops predictions and compares after every edge.
module tb_id_ex_stage;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 2;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_id, rs1_used, rs2_used, rf_we_id, rf_we_mem, rf_we_wb, flush;
  logic [31:0] pc_id, rD1, rD2, sext, alu_c_ex, wD_mem, wD;
  logic [4:0] rR1, rR2, wR_id, wR_mem, wR_wb;
  logic [1:0] wd_sel_id;
  logic [CTRL_W-1:0] ctrl_id;
  logic stall_o, valid_ex, rf_we_ex;
  logic [31:0] pc_ex, rD1_ex, rD2_ex, sext_ex;
  logic [4:0] wR_ex;
  logic [1:0] wd_sel_ex;
  logic [CTRL_W-1:0] ctrl_ex;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .pc_id(pc_id),
    .rR1(rR1), .rR2(rR2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rD1(rD1), .rD2(rD2), .sext(sext), .wR_id(wR_id), .rf_we_id(rf_we_id),
    .wd_sel_id(wd_sel_id), .ctrl_id(ctrl_id), .alu_c_ex(alu_c_ex),
    .wD_mem(wD_mem), .wR_mem(wR_mem), .rf_we_mem(rf_we_mem),
    .wD(wD), .wR_wb(wR_wb), .rf_we_wb(rf_we_wb), .flush(flush),
    .stall_o(stall_o), .valid_ex(valid_ex), .pc_ex(pc_ex), .rD1_ex(rD1_ex),
    .rD2_ex(rD2_ex), .sext_ex(sext_ex), .wR_ex(wR_ex), .rf_we_ex(rf_we_ex),
    .wd_sel_ex(wd_sel_ex), .ctrl_ex(ctrl_ex), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic valid;
    logic [31:0] pc, rd1, rd2, sext;
    logic [4:0] wr;
    logic we;
    logic [1:0] wd_sel;
    logic [CTRL_W-1:0] ctrl;
    logic rs1u, rs2u;
    logic [CNT_W-1:0] sc, fc;
  } slot_t;

  slot_t q[$];
  slot_t m;
  logic m_stall, stall_seen;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.pc = 0; s.rd1 = 0; s.rd2 = 0; s.sext = 0; s.wr = 0; s.we = 0;
    s.wd_sel = 0; s.ctrl = 0; s.rs1u = 0; s.rs2u = 0; s.sc = 0; s.fc = 0;
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CMAX) ? c : c + 1'b1;
  endfunction

  // Youngest producer writing src wins; the EX value depends on what that instruction writes back.
  function automatic logic [31:0] ref_operand(input logic [4:0] src, input logic [31:0] rf_val);
    logic hit[3];
    logic [4:0] dst[3];
    logic [31:0] val[3];
    if (src == 0) return rf_val;
    hit[0] = m.valid && m.we && m.wd_sel != 2'b01;
    dst[0] = m.wr;
    val[0] = (m.wd_sel == 2'b10) ? m.pc + 32'd4 : (m.wd_sel == 2'b11) ? m.sext : alu_c_ex;
    hit[1] = rf_we_mem; dst[1] = wR_mem; val[1] = wD_mem;
    hit[2] = rf_we_wb;  dst[2] = wR_wb;  val[2] = wD;
    for (int i = 0; i < 3; i++)
      if (hit[i] && dst[i] == src) return val[i];
    return rf_val;
  endfunction

  task automatic idle();
    valid_id = 0; pc_id = 0; rR1 = 0; rR2 = 0; rs1_used = 0; rs2_used = 0;
    rD1 = 0; rD2 = 0; sext = 0; wR_id = 0; rf_we_id = 0; wd_sel_id = 0; ctrl_id = 0;
    alu_c_ex = 0; wD_mem = 0; wR_mem = 0; rf_we_mem = 0; wD = 0; wR_wb = 0; rf_we_wb = 0;
    flush = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    slot_t nx;
    logic lu;
    #1;
    lu = m.valid && valid_id && m.we && m.wd_sel == 2'b01 && m.wr != 0 &&
         ((rs1_used && rR1 == m.wr) || (rs2_used && rR2 == m.wr));
    m_stall = lu && !flush;
    stall_seen = stall_o;
    chk("stall_o", {31'b0, stall_o}, {31'b0, m_stall});
    nx = empty_slot();
    if (!flush && !lu && valid_id) begin
      nx.valid = 1; nx.pc = pc_id; nx.sext = sext; nx.wr = wR_id; nx.we = rf_we_id;
      nx.wd_sel = wd_sel_id; nx.ctrl = ctrl_id; nx.rs1u = rs1_used; nx.rs2u = rs2_used;
      nx.rd1 = ref_operand(rR1, rD1);
      nx.rd2 = ref_operand(rR2, rD2);
    end
    nx.sc = m_stall ? sat_inc(m.sc) : m.sc;
    nx.fc = flush ? sat_inc(m.fc) : m.fc;
    q.push_back(nx);
    m = nx;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    chk("rst valid_ex", {31'b0, valid_ex}, 0);
    chk("rst pc_ex", pc_ex, 0);
    chk("rst rD1_ex", rD1_ex, 0);
    chk("rst rD2_ex", rD2_ex, 0);
    chk("rst sext_ex", sext_ex, 0);
    chk("rst ctl", {22'b0, ctrl_ex, wR_ex, wd_sel_ex, rf_we_ex}, 0);
    chk("rst stall_o", {31'b0, stall_o}, 0);
    chk("rst counters", {28'b0, stall_cnt, flush_cnt}, 0);
    m = empty_slot();
    m_stall = 0;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin : monitor
    slot_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid_ex", {31'b0, valid_ex}, {31'b0, e.valid});
        chk("pc_ex", pc_ex, e.pc);
        if (!e.valid || e.rs1u) chk("rD1_ex", rD1_ex, e.rd1);
        if (!e.valid || e.rs2u) chk("rD2_ex", rD2_ex, e.rd2);
        chk("sext_ex", sext_ex, e.sext);
        chk("wR_ex", {27'b0, wR_ex}, {27'b0, e.wr});
        chk("rf_we_ex", {31'b0, rf_we_ex}, {31'b0, e.we});
        chk("wd_sel_ex", {30'b0, wd_sel_ex}, {30'b0, e.wd_sel});
        chk("ctrl_ex", {24'b0, ctrl_ex}, {24'b0, e.ctrl});
        chk("stall_cnt", {30'b0, stall_cnt}, {30'b0, e.sc});
        chk("flush_cnt", {30'b0, flush_cnt}, {30'b0, e.fc});
      end
    end
  end

  initial begin : driver
    logic [4:0] ld_rd;
    idle();
    m = empty_slot();
    m_stall = 0;
    @(negedge clk);
    do_reset();

    // EX forward of an ALU result
    idle(); valid_id = 1; pc_id = 32'h100; rR1 = 1; rs1_used = 1; wR_id = 5; rf_we_id = 1; ctrl_id = 8'h01;
    step();
    idle(); valid_id = 1; pc_id = 32'h104; rR1 = 5; rs1_used = 1; rD1 = 0; alu_c_ex = 32'h10; wR_id = 9; rf_we_id = 1;
    step();
    chk("exfwd rD1_ex", rD1_ex, 32'h10);
    chk("exfwd stall", {31'b0, stall_seen}, 0);

    // Load-use: one bubble, then MEM forward
    idle(); valid_id = 1; pc_id = 32'h108; wR_id = 6; rf_we_id = 1; wd_sel_id = 2'b01;
    step();
    idle(); valid_id = 1; pc_id = 32'h10C; rR1 = 6; rR2 = 6; rs1_used = 1; rs2_used = 1; wR_id = 7; rf_we_id = 1;
    step();
    chk("lu stall", {31'b0, stall_seen}, 1);
    chk("lu bubble", {31'b0, valid_ex}, 0);
    chk("lu stall_cnt", {30'b0, stall_cnt}, 1);
    rf_we_mem = 1; wR_mem = 6; wD_mem = 32'hABCD;
    step();
    chk("lu stall2", {31'b0, stall_seen}, 0);
    chk("lu rD1_ex", rD1_ex, 32'hABCD);
    chk("lu rD2_ex", rD2_ex, 32'hABCD);

    // EX > MEM > WB priority
    idle(); valid_id = 1; wR_id = 8; rf_we_id = 1;
    step();
    idle(); valid_id = 1; rR2 = 8; rs2_used = 1; rD2 = 32'hDEAD; alu_c_ex = 1;
    rf_we_mem = 1; wR_mem = 8; wD_mem = 2; rf_we_wb = 1; wR_wb = 8; wD = 3;
    step();
    chk("prio rD2_ex", rD2_ex, 1);

    // x0 never forwarded
    idle(); valid_id = 1; wR_id = 0; rf_we_id = 1;
    step();
    idle(); valid_id = 1; rR1 = 0; rs1_used = 1; rD1 = 0; alu_c_ex = 32'h55;
    rf_we_mem = 1; wR_mem = 0; wD_mem = 32'h66; rf_we_wb = 1; wR_wb = 0; wD = 32'h77;
    step();
    chk("x0 rD1_ex", rD1_ex, 0);

    // Flush beats load-use
    idle(); valid_id = 1; wR_id = 6; rf_we_id = 1; wd_sel_id = 2'b01;
    step();
    idle(); valid_id = 1; rR1 = 6; rR2 = 6; rs1_used = 1; rs2_used = 1; wR_id = 7; rf_we_id = 1; flush = 1;
    step();
    chk("flush stall", {31'b0, stall_seen}, 0);
    chk("flush bubble", {31'b0, valid_ex}, 0);
    chk("flush flush_cnt", {30'b0, flush_cnt}, 1);
    chk("flush stall_cnt", {30'b0, stall_cnt}, 1);

    // Counter saturation
    idle(); flush = 1;
    for (int i = 0; i < 5; i++) step();
    chk("sat flush_cnt", {30'b0, flush_cnt}, 3);

    // JAL link value wraps
    idle(); valid_id = 1; pc_id = 32'hFFFF_FFFC; wR_id = 1; rf_we_id = 1; wd_sel_id = 2'b10;
    step();
    idle(); valid_id = 1; pc_id = 32'h0; rR1 = 1; rs1_used = 1; rD1 = 32'h1234;
    step();
    chk("jal rD1_ex", rD1_ex, 0);

    // Asynchronous reset with a live instruction in EX
    chk("pre-rst valid_ex", {31'b0, valid_ex}, 1);
    idle();
    do_reset();

    // Randomized traffic
    ld_rd = 0;
    for (int n = 0; n < 1500; n++) begin
      if (m_stall) begin
        rf_we_mem = 1; wR_mem = ld_rd; wD_mem = $urandom;
        rf_we_wb = $urandom_range(0, 1); wR_wb = 5'($urandom_range(0, 7)); wD = $urandom;
        alu_c_ex = $urandom;
        flush = ($urandom_range(0, 9) == 0);
      end else begin
        valid_id = ($urandom_range(0, 99) < 85);
        pc_id = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
        rR1 = 5'($urandom_range(0, 7)); rR2 = 5'($urandom_range(0, 7));
        rs1_used = $urandom_range(0, 1); rs2_used = $urandom_range(0, 1);
        rD1 = $urandom; rD2 = $urandom; sext = $urandom;
        wR_id = 5'($urandom_range(0, 7)); rf_we_id = $urandom_range(0, 1);
        wd_sel_id = 2'($urandom_range(0, 3)); ctrl_id = 8'($urandom);
        alu_c_ex = $urandom;
        rf_we_mem = $urandom_range(0, 1); wR_mem = 5'($urandom_range(0, 7)); wD_mem = $urandom;
        rf_we_wb = $urandom_range(0, 1); wR_wb = 5'($urandom_range(0, 7)); wD = $urandom;
        flush = ($urandom_range(0, 9) == 0);
      end
      ld_rd = m.wr;
      step();
      if (n % 300 == 299) do_reset();
    end

    @(posedge clk);
    #2;
    chk("scoreboard drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
